mem_port_arbiter: RTL

//  Shares one single-ported, variable-latency memory between the IF-stage fetch port and the MEM-stage load/store port.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory-side bundle for mem_port_arbiter.
// The arbiter binds to slave; the requesters and memory (or a bench) bind to master.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ready;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              stall_if;
   logic              stall_mem;
   logic              timeout;

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem, timeout
   );

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem, timeout
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch and load/store ports, with a watchdog.
// Optional round-robin tie-breaking is enabled by defining ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus,
   output logic [1:0]          dbg_state
);
   // Handshake: a requester holds x_req until x_ready pulses for one cycle; the memory
   // answers each mem_req with a single mem_ack strobe while mem_req is still high.
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_DM = 2'd2} state_t;

   localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [7:0]        wdog, wdog_nxt;
   logic              busy, done, abort;
   logic              elig_if, elig_dm, dm_wins, grant_if, grant_dm;
   logic              mem_req_nxt, mem_we_nxt, if_ready_nxt, dm_ready_nxt, timeout_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt, if_rdata_nxt, dm_rdata_nxt;

   // A requester whose ready is high this cycle is still holding a stale req.
   assign elig_if       = bus.if_req & ~bus.if_ready;
   assign elig_dm       = bus.dm_req & ~bus.dm_ready;
   assign bus.stall_if  = elig_if;
   assign bus.stall_mem = elig_dm;
   assign dbg_state     = state;

   assign busy  = (state == BUSY_IF) || (state == BUSY_DM);
   assign done  = busy & bus.mem_ack;
   assign abort = busy & ~bus.mem_ack & (wdog == WDOG_LAST);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant;  // 0 = IF, 1 = DM

   assign dm_wins = ~last_grant;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        last_grant <= 1'b0;
      else if (grant_dm) last_grant <= 1'b1;
      else if (grant_if) last_grant <= 1'b0;
   end
`else
   assign dm_wins = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         wdog          <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.if_rdata  <= '0;
         bus.if_ready  <= 1'b0;
         bus.dm_rdata  <= '0;
         bus.dm_ready  <= 1'b0;
         bus.timeout   <= 1'b0;
      end else begin
         state         <= state_nxt;
         wdog          <= wdog_nxt;
         bus.mem_req   <= mem_req_nxt;
         bus.mem_we    <= mem_we_nxt;
         bus.mem_addr  <= mem_addr_nxt;
         bus.mem_wdata <= mem_wdata_nxt;
         bus.if_rdata  <= if_rdata_nxt;
         bus.if_ready  <= if_ready_nxt;
         bus.dm_rdata  <= dm_rdata_nxt;
         bus.dm_ready  <= dm_ready_nxt;
         bus.timeout   <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_dm  = 1'b0;
      case (state)
         IDLE: begin
            if (elig_dm && (dm_wins || !elig_if)) grant_dm = 1'b1;
            else if (elig_if)                     grant_if = 1'b1;
         end
         BUSY_IF: if (done && elig_dm) grant_dm = 1'b1;
         BUSY_DM: if (done && elig_if) grant_if = 1'b1;
         default: ;
      endcase
      // Re-grant on the ack edge so back-to-back accesses see no IDLE bubble.
      if (grant_dm)           state_nxt = BUSY_DM;
      else if (grant_if)      state_nxt = BUSY_IF;
      else if (done || abort) state_nxt = IDLE;
      else if (!busy)         state_nxt = IDLE;
   end

   always_comb begin
      mem_req_nxt   = bus.mem_req;
      mem_we_nxt    = bus.mem_we;
      mem_addr_nxt  = bus.mem_addr;
      mem_wdata_nxt = bus.mem_wdata;
      if_rdata_nxt  = bus.if_rdata;
      dm_rdata_nxt  = bus.dm_rdata;
      if_ready_nxt  = 1'b0;
      dm_ready_nxt  = 1'b0;
      timeout_nxt   = abort;
      wdog_nxt      = busy ? wdog + 8'd1 : 8'd0;
      if (done || abort) begin
         mem_req_nxt = 1'b0;
         wdog_nxt    = 8'd0;
         // An aborted access still completes its handshake, with zero data.
         if (state == BUSY_IF) begin
            if_ready_nxt = 1'b1;
            if_rdata_nxt = done ? bus.mem_rdata : '0;
         end else begin
            dm_ready_nxt = 1'b1;
            dm_rdata_nxt = done ? bus.mem_rdata : '0;
         end
      end
      if (grant_if) begin
         mem_req_nxt   = 1'b1;
         mem_we_nxt    = 1'b0;
         mem_addr_nxt  = bus.if_addr;
         mem_wdata_nxt = '0;
         wdog_nxt      = 8'd0;
      end
      if (grant_dm) begin
         mem_req_nxt   = 1'b1;
         mem_we_nxt    = bus.dm_we;
         mem_addr_nxt  = bus.dm_addr;
         mem_wdata_nxt = bus.dm_wdata;
         wdog_nxt      = 8'd0;
      end
   end
endmodule
